// File: rtl/crc_pkg.sv
// Shared types and constants for the MBox channel-buffer sequencer.
// Optional feature macro: CRC_OVERRUN_ERR_EN (see crc_ch_buf_ctl.sv).
package crc_pkg;

  localparam int CRC_DEPTH = 128;
  localparam int CRC_ADR_W = $clog2(CRC_DEPTH);

  // Sequencer phases: IDLE waits for a grant, T0 sets up the address,
  // T1 strobes the write (or lets read data settle), T2 completes/advances,
  // HOLD keeps a read word on CBUS until the channel acknowledges it.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    HOLD = 3'd4
  } crc_st_t;

endpackage

// File: rtl/crc_ch_buf_ctl_if.sv
// Bundle of request/acknowledge, strobe and status signals between the
// channel-buffer sequencer (slave modport) and its requesters / data slices
// (master modport). Debug taps expose FSM state, pointers and fill count.
//
// Handshakes: mb_wr_req_h is a level held by the MB side until the 1-clock
// mb_wr_done_h pulse; cbus_rd_req_h is a level held by the channel until it
// raises cbus_ack_h while crc_cbus_out_hold_h is high. A request dropped
// after the sequencer has started the operation does not cancel it.
interface crc_ch_buf_ctl_if #(parameter int ADR_W = crc_pkg::CRC_ADR_W);
  import crc_pkg::*;

  logic             mb_wr_req_h;
  logic             cbus_rd_req_h;
  logic             cbus_ack_h;
  logic             ch_reverse_h;
  logic             ch_buf_clr_h;

  logic [ADR_W-1:0] crc_ch_buf_adr_h;
  logic             ch_buf_wr_l;
  logic             ch_t0_l;
  logic             ch_t2_l;
  logic             crc_cbus_out_hold_h;
  logic             mb_wr_done_h;
  logic             buf_full_h;
  logic             buf_empty_h;
  logic             buf_overrun_h;

  crc_st_t          dbg_state;
  logic [ADR_W-1:0] dbg_wptr;
  logic [ADR_W-1:0] dbg_rptr;
  logic [ADR_W:0]   dbg_count;

  modport slave (
    input  mb_wr_req_h, cbus_rd_req_h, cbus_ack_h, ch_reverse_h, ch_buf_clr_h,
    output crc_ch_buf_adr_h, ch_buf_wr_l, ch_t0_l, ch_t2_l, crc_cbus_out_hold_h,
    output mb_wr_done_h, buf_full_h, buf_empty_h, buf_overrun_h,
    output dbg_state, dbg_wptr, dbg_rptr, dbg_count
  );

  modport master (
    output mb_wr_req_h, cbus_rd_req_h, cbus_ack_h, ch_reverse_h, ch_buf_clr_h,
    input  crc_ch_buf_adr_h, ch_buf_wr_l, ch_t0_l, ch_t2_l, crc_cbus_out_hold_h,
    input  mb_wr_done_h, buf_full_h, buf_empty_h, buf_overrun_h,
    input  dbg_state, dbg_wptr, dbg_rptr, dbg_count
  );

endinterface

// File: rtl/crc_ring_ptr.sv
// Ring-buffer pointer: advances +1 or -1 modulo 2**ADR_W, synchronous clear.
// ptr_nxt is exported so the caller can latch the post-advance address.
module crc_ring_ptr #(
  parameter int ADR_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic             dec,
  output logic [ADR_W-1:0] ptr,
  output logic [ADR_W-1:0] ptr_nxt
);

  // Next pointer: clear wins over advance; wrap is the natural power-of-two rollover.
  always_comb begin
    ptr_nxt = ptr;
    if (clr) begin
      ptr_nxt = '0;
    end else if (adv) begin
      ptr_nxt = dec ? (ptr - 1'b1) : (ptr + 1'b1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/crc_ch_buf_ctl.sv
// Channel-buffer address/timing sequencer for the MBox channel data path.
// Arbitrates MB writes against CBUS reads on a ring buffer, sequences the
// T0/T1/T2 phases, tracks fill count, full/empty and transfer direction.
// Optional feature macro: CRC_OVERRUN_ERR_EN enables the sticky overrun flag.
module crc_ch_buf_ctl
  import crc_pkg::*;
#(
  parameter int DEPTH = CRC_DEPTH
) (
  input logic               clk_h,
  input logic               reset_l,
  crc_ch_buf_ctl_if.slave   bus
);

  localparam int ADR_W = $clog2(DEPTH);
  localparam logic [ADR_W:0] CNT_FULL   = (ADR_W+1)'(DEPTH);
  localparam logic [ADR_W:0] CNT_ALMOST = (ADR_W+1)'(DEPTH - 1);
  localparam logic [ADR_W:0] CNT_NEAR   = (ADR_W+1)'(DEPTH - 2);

  crc_st_t          state_q, state_d;
  logic             op_wr_q;      // current/last op is a write
  logic             last_wr_q;    // last grant was a write
  logic             clr_pend_q;   // flush requested mid-operation
  logic             rev_q;
  logic [ADR_W:0]   count_q, count_d;
  logic             full_q, empty_q;
  logic [ADR_W-1:0] adr_q;

  logic             grant_wr, grant_rd, clr_now, adv_w, adv_r, clr_t2;
  logic             wr_ok, rd_ok;
  logic [ADR_W-1:0] wptr, wptr_nxt, rptr, rptr_nxt;

  assign wr_ok  = bus.mb_wr_req_h & ~full_q;
  assign rd_ok  = bus.cbus_rd_req_h & ~empty_q;
  assign clr_t2 = clr_pend_q | bus.ch_buf_clr_h;

  crc_ring_ptr #(.ADR_W(ADR_W)) u_wptr (
    .clk     (clk_h),
    .rst_n   (reset_l),
    .clr     (clr_now),
    .adv     (adv_w),
    .dec     (rev_q),
    .ptr     (wptr),
    .ptr_nxt (wptr_nxt)
  );

  crc_ring_ptr #(.ADR_W(ADR_W)) u_rptr (
    .clk     (clk_h),
    .rst_n   (reset_l),
    .clr     (clr_now),
    .adv     (adv_r),
    .dec     (rev_q),
    .ptr     (rptr),
    .ptr_nxt (rptr_nxt)
  );

  // Next-state, arbitration, pointer advance and count update.
  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    clr_now  = 1'b0;
    adv_w    = 1'b0;
    adv_r    = 1'b0;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (bus.ch_buf_clr_h) begin
          // A flush takes the whole clock; no grant alongside it.
          clr_now = 1'b1;
        end else if (wr_ok && !(rd_ok && last_wr_q && count_q == CNT_ALMOST)) begin
          grant_wr = 1'b1;
          state_d  = T0;
        end else if (rd_ok) begin
          grant_rd = 1'b1;
          state_d  = T0;
        end
      end
      T0: state_d = T1;
      T1: state_d = T2;
      T2: begin
        if (clr_t2) begin
          // Deferred flush: the op's own count/pointer update is dropped.
          clr_now = 1'b1;
        end else if (op_wr_q) begin
          adv_w   = 1'b1;
          count_d = count_q + 1'b1;
        end else begin
          adv_r   = 1'b1;
          count_d = count_q - 1'b1;
        end
        if (op_wr_q) begin
          state_d = IDLE;
          // Chain straight into the next write unless that write would fill
          // the buffer while a read is waiting (IDLE then hands it to the read).
          if (!clr_t2 && bus.mb_wr_req_h && count_q != CNT_ALMOST &&
              !(bus.cbus_rd_req_h && count_q == CNT_NEAR)) begin
            grant_wr = 1'b1;
            state_d  = T0;
          end
        end else begin
          state_d = bus.cbus_ack_h ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (bus.ch_buf_clr_h) clr_now = 1'b1;
        if (bus.cbus_ack_h) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_now) count_d = '0;
  end

  // FSM state register.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Grant bookkeeping, latched address and mid-op flush request.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      op_wr_q    <= 1'b0;
      last_wr_q  <= 1'b0;
      adr_q      <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      if (grant_wr || grant_rd) begin
        op_wr_q   <= grant_wr;
        last_wr_q <= grant_wr;
        adr_q     <= grant_wr ? wptr_nxt : rptr_nxt;
      end
      if (state_q == T2)                                  clr_pend_q <= 1'b0;
      else if ((state_q == T0 || state_q == T1) && bus.ch_buf_clr_h) clr_pend_q <= 1'b1;
    end
  end

  // Fill count with full/empty flags registered alongside it.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // Direction latch: only follows ch_reverse_h while idle and empty.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l)                             rev_q <= 1'b0;
    else if (state_q == IDLE && count_q == '0) rev_q <= bus.ch_reverse_h;
  end

`ifdef CRC_OVERRUN_ERR_EN
  logic wr_wait_q, rd_wait_q, overrun_q;
  logic wr_stall, rd_stall;

  // A stall is a request left waiting in IDLE against a full/empty buffer.
  assign wr_stall = (state_q == IDLE) & bus.mb_wr_req_h & full_q;
  assign rd_stall = (state_q == IDLE) & bus.cbus_rd_req_h & empty_q;

  // Sticky overrun once a stall persists for a second clock.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      wr_wait_q <= 1'b0;
      rd_wait_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_wait_q <= wr_stall;
      rd_wait_q <= rd_stall;
      if (bus.ch_buf_clr_h)                                        overrun_q <= 1'b0;
      else if ((wr_stall && wr_wait_q) || (rd_stall && rd_wait_q)) overrun_q <= 1'b1;
    end
  end

  assign bus.buf_overrun_h = overrun_q;
`else
  assign bus.buf_overrun_h = 1'b0;
`endif

  // Phase strobes decode directly from state so reset releases them at once.
  assign bus.ch_t0_l             = ~(state_q == T0);
  assign bus.ch_buf_wr_l         = ~((state_q == T1) && op_wr_q);
  assign bus.ch_t2_l             = ~(state_q == T2);
  assign bus.mb_wr_done_h        = (state_q == T2) && op_wr_q;
  assign bus.crc_cbus_out_hold_h = ((state_q == T2) && !op_wr_q) || (state_q == HOLD);
  assign bus.crc_ch_buf_adr_h    = adr_q;
  assign bus.buf_full_h          = full_q;
  assign bus.buf_empty_h         = empty_q;

  assign bus.dbg_state = state_q;
  assign bus.dbg_wptr  = wptr;
  assign bus.dbg_rptr  = rptr;
  assign bus.dbg_count = count_q;

endmodule
